dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single-port data RAM (6-bit address, 16-bit data) between the CPU core's load/store port and an auxiliary requester (debug loader / DMA). It sits between `cpu_core`, the aux master and `Data_Memory_main`, replacing their direct wiring in the system top.
- CPU has fixed priority; a starvation guard bounds aux wait time.
- A read-tag pipeline routes registered RAM read data back to the issuing port.

Parameters:
ADDR_W, 6, data memory address width
DATA_W, 16, data word width
AUX_MAX_WAIT, 4, max consecutive cycles aux may be refused before it is forced to win (1..15)

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  reset, synchronous, active-high
cpu_rd_en  in  1  CPU load request
cpu_wr_en  in  1  CPU store request
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU store data
cpu_stall  out  1  CPU request present but not granted this cycle
cpu_rdata  out  DATA_W  read data to CPU
cpu_rvalid  out  1  cpu_rdata valid (one cycle)
aux_req  in  1  aux request; held with stable fields until granted
aux_we  in  1  aux write (1) / read (0)
aux_addr  in  ADDR_W  aux address
aux_wdata  in  DATA_W  aux write data
aux_gnt  out  1  aux request accepted this cycle
aux_rdata  out  DATA_W  read data to aux
aux_rvalid  out  1  aux_rdata valid (one cycle)
mem_rd_en  out  1  to RAM read enable
mem_wr_en  out  1  to RAM write enable
mem_addr  out  ADDR_W  to RAM address
mem_wdata  out  DATA_W  to RAM write data
mem_rdata  in  DATA_W  from RAM; valid cycle after mem_rd_en

Behaviour:
- cpu_active = cpu_rd_en | cpu_wr_en. If both are set, the write wins and the read is dropped (no cpu_rvalid).
- Grant decision is combinational each cycle:
  - force_aux = aux_req & (wait_cnt == AUX_MAX_WAIT).
  - Aux wins if aux_req & (force_aux | ~cpu_active); otherwise the CPU wins if cpu_active.
- mem_* outputs mirror the winner's fields. With no winner: mem_rd_en = mem_wr_en = 0; mem_addr and mem_wdata = 0.
- aux_gnt = aux won. cpu_stall = cpu_active & ~cpu won.
- wait_cnt (4 bits):
  - rst → 0.
  - aux_req & ~aux_gnt → increment, saturating at AUX_MAX_WAIT.
  - aux_gnt or ~aux_req → 0.
- Read tag register rd_tag, states NONE/CPU/AUX:
  - Next value is CPU or AUX for the read issued this cycle, else NONE.
  - cpu_rvalid = (rd_tag == CPU); aux_rvalid = (rd_tag == AUX). Latency is exactly 1 cycle from issue.
  - cpu_rdata and aux_rdata both pass mem_rdata through; only the valids qualify them.
- Back-to-back accesses: one access issued per cycle, reads pipelined with no bubble.
- Write followed by a read of the same address on the next cycle returns the new data; RAM ordering is preserved because accesses are serialized.
- Reset values:
  - rd_tag = NONE, wait_cnt = 0.
  - cpu_rvalid, aux_rvalid, aux_gnt, cpu_stall = 0 during rst; mem_rd_en, mem_wr_en = 0 during rst.
  - An in-flight read at reset produces no rvalid.
- A stalled CPU must hold its request; the arbiter does not buffer it.

Optional Feature:
DMEM_ARB_PERF_EN:
- Defined: adds outputs perf_cpu_stall[15:0] and perf_aux_wait[15:0].
  - Saturating counters of cycles with cpu_stall = 1 and cycles with aux_req & ~aux_gnt.
  - Cleared by rst.
- Undefined: no such ports or logic; the block is otherwise identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - ADDR_W / DATA_W defaults.
  - rd_tag encoding TAG_NONE = 2'b00, TAG_CPU = 2'b01, TAG_AUX = 2'b10.
- One sub-module, sat_counter (parameterized width and limit, synchronous clear, enable), used for wait_cnt and the perf counters.

Test Plan:
1. CPU reads addr 5 (RAM preloaded 0x1234), aux idle → mem_rd_en same cycle; next cycle cpu_rvalid = 1, cpu_rdata = 0x1234, cpu_stall = 0.
2. Aux writes 0xBEEF to addr 10, CPU idle → aux_gnt = 1 that cycle. Then aux read of addr 10 → aux_rvalid = 1 next cycle with 0xBEEF.
3. CPU requests every cycle and aux_req held, AUX_MAX_WAIT = 4 → aux refused 4 cycles; granted on the 5th; cpu_stall = 1 exactly that cycle; wait_cnt returns to 0.
4. Alternating CPU read addr 1 and aux read addr 2 on consecutive cycles → rvalids alternate cpu/aux with correct data, no gaps.
5. rst asserted the cycle after a CPU read issue → no cpu_rvalid; all outputs 0 while rst = 1.
6. cpu_rd_en = cpu_wr_en = 1 to addr 3, data 0x00FF → RAM addr 3 = 0x00FF; no cpu_rvalid. With DMEM_ARB_PERF_EN, scenario 3 gives perf_cpu_stall = 1 and perf_aux_wait = 4.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Read-tag encoding routes returning RAM data to its issuing port.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_CPU  = 2'b01,
        TAG_AUX  = 2'b10
    } rd_tag_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// Holds at LIMIT once reached until cleared.
module sat_counter #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 15
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (en && (count != LIM)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: CPU fixed priority, aux starvation guard, read-tag return path.
// Optional DMEM_ARB_PERF_EN adds stall / aux-wait saturating counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int AUX_MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd_en,
    input  logic              cpu_wr_en,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_gnt,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              aux_rvalid,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [15:0]       perf_cpu_stall,
    output logic [15:0]       perf_aux_wait
`endif
);

    logic       cpu_active;
    logic       force_aux;
    logic       aux_win;
    logic       cpu_win;
    logic       aux_wait;
    logic [3:0] wait_cnt;
    rd_tag_e    rd_tag;
    rd_tag_e    rd_tag_nxt;

    assign cpu_active = cpu_rd_en | cpu_wr_en;
    assign force_aux  = aux_req & (wait_cnt == 4'(AUX_MAX_WAIT));

    // Nothing is granted while in reset so the RAM sees no access.
    assign aux_win = ~rst & aux_req & (force_aux | ~cpu_active);
    assign cpu_win = ~rst & cpu_active & ~aux_win;

    assign aux_gnt   = aux_win;
    assign cpu_stall = ~rst & cpu_active & ~cpu_win;
    assign aux_wait  = aux_req & ~aux_gnt;

    always_comb begin
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        rd_tag_nxt = TAG_NONE;
        if (aux_win) begin
            mem_rd_en = ~aux_we;
            mem_wr_en = aux_we;
            mem_addr  = aux_addr;
            mem_wdata = aux_wdata;
            if (!aux_we) rd_tag_nxt = TAG_AUX;
        end else if (cpu_win) begin
            // A simultaneous read is dropped in favour of the write.
            mem_rd_en = ~cpu_wr_en;
            mem_wr_en = cpu_wr_en;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            if (!cpu_wr_en) rd_tag_nxt = TAG_CPU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rd_tag <= TAG_NONE;
        else     rd_tag <= rd_tag_nxt;
    end

    assign cpu_rvalid = ~rst & (rd_tag == TAG_CPU);
    assign aux_rvalid = ~rst & (rd_tag == TAG_AUX);
    assign cpu_rdata  = mem_rdata;
    assign aux_rdata  = mem_rdata;

    sat_counter #(
        .WIDTH (4),
        .LIMIT (AUX_MAX_WAIT)
    ) u_wait_cnt (
        .clk   (clk),
        .clr   (rst | ~aux_wait),
        .en    (aux_wait),
        .count (wait_cnt)
    );

`ifdef DMEM_ARB_PERF_EN
    sat_counter #(
        .WIDTH (16),
        .LIMIT (65535)
    ) u_perf_stall (
        .clk   (clk),
        .clr   (rst),
        .en    (cpu_stall),
        .count (perf_cpu_stall)
    );

    sat_counter #(
        .WIDTH (16),
        .LIMIT (65535)
    ) u_perf_wait (
        .clk   (clk),
        .clr   (rst),
        .en    (aux_wait),
        .count (perf_aux_wait)
    );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port RAM.
// Inputs change 1ns after posedge; outputs sampled 1ns after that.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_rd_en, cpu_wr_en;
    logic [5:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_stall;
    logic [15:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        aux_req, aux_we;
    logic [5:0]  aux_addr;
    logic [15:0] aux_wdata;
    logic        aux_gnt;
    logic [15:0] aux_rdata;
    logic        aux_rvalid;
    logic        mem_rd_en, mem_wr_en;
    logic [5:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0] perf_cpu_stall, perf_aux_wait;
`endif

    logic [15:0] ram [64];
    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_addr] <= mem_wdata;
        if (mem_rd_en) mem_rdata <= ram[mem_addr];
    end

    dmem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_rd_en  (cpu_rd_en),
        .cpu_wr_en  (cpu_wr_en),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .aux_req    (aux_req),
        .aux_we     (aux_we),
        .aux_addr   (aux_addr),
        .aux_wdata  (aux_wdata),
        .aux_gnt    (aux_gnt),
        .aux_rdata  (aux_rdata),
        .aux_rvalid (aux_rvalid),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_cpu_stall (perf_cpu_stall),
        .perf_aux_wait  (perf_aux_wait)
`endif
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_rd_en = 0; cpu_wr_en = 0; cpu_addr = 0; cpu_wdata = 0;
        aux_req = 0; aux_we = 0; aux_addr = 0; aux_wdata = 0;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        rst = 1; idle();
        next_cycle();
        cpu_rd_en = 1; cpu_addr = 6'd5; aux_req = 1;
        #1;
        got = {cpu_rvalid, aux_rvalid, aux_gnt, cpu_stall, mem_rd_en, mem_wr_en};
        total_cnt++;
        if (got !== 6'b0) $display("FAIL reset_outputs got=%b exp=000000", got);
        else pass_cnt++;
        next_cycle();
        rst = 0; idle();
        #1;
        total_cnt++;
        if ({cpu_rvalid, aux_rvalid} !== 2'b00)
            $display("FAIL reset_rvalid got=%b exp=00", {cpu_rvalid, aux_rvalid});
        else pass_cnt++;
    endtask

    task automatic test_cpu_read();
        next_cycle();
        cpu_rd_en = 1; cpu_addr = 6'd5;
        #1;
        total_cnt++;
        if ({mem_rd_en, mem_wr_en, mem_addr, cpu_stall} !== {1'b1, 1'b0, 6'd5, 1'b0})
            $display("FAIL cpu_rd_issue got rd=%b wr=%b addr=%0d stall=%b exp 1 0 5 0",
                     mem_rd_en, mem_wr_en, mem_addr, cpu_stall);
        else pass_cnt++;
        next_cycle();
        idle();
        #1;
        total_cnt++;
        if ({cpu_rvalid, aux_rvalid, cpu_rdata} !== {1'b1, 1'b0, 16'h1234})
            $display("FAIL cpu_rd_data got v=%b av=%b d=%h exp 1 0 1234",
                     cpu_rvalid, aux_rvalid, cpu_rdata);
        else pass_cnt++;
    endtask

    task automatic test_aux_write_read();
        next_cycle();
        aux_req = 1; aux_we = 1; aux_addr = 6'd10; aux_wdata = 16'hBEEF;
        #1;
        total_cnt++;
        if ({aux_gnt, mem_wr_en, mem_rd_en, mem_addr, mem_wdata} !==
            {1'b1, 1'b1, 1'b0, 6'd10, 16'hBEEF})
            $display("FAIL aux_wr got gnt=%b wr=%b rd=%b a=%0d d=%h exp 1 1 0 10 beef",
                     aux_gnt, mem_wr_en, mem_rd_en, mem_addr, mem_wdata);
        else pass_cnt++;
        next_cycle();
        aux_we = 0;
        #1;
        total_cnt++;
        if ({aux_gnt, mem_rd_en, aux_rvalid} !== 3'b110)
            $display("FAIL aux_rd_issue got gnt=%b rd=%b av=%b exp 1 1 0",
                     aux_gnt, mem_rd_en, aux_rvalid);
        else pass_cnt++;
        next_cycle();
        idle();
        #1;
        total_cnt++;
        if ({aux_rvalid, cpu_rvalid, aux_rdata} !== {1'b1, 1'b0, 16'hBEEF})
            $display("FAIL aux_rd_data got av=%b cv=%b d=%h exp 1 0 beef",
                     aux_rvalid, cpu_rvalid, aux_rdata);
        else pass_cnt++;
    endtask

    task automatic test_starvation();
        logic [3:0] got;
        logic [3:0] exp;
        logic [15:0] exp_d;
        for (int k = 0; k < 7; k++) begin
            next_cycle();
            cpu_rd_en = (k < 6); cpu_addr = 6'd1;
            aux_req = (k < 6); aux_we = 0; aux_addr = 6'd2;
            #1;
            // Refused on cycles 0-3, forced win on cycle 4, fresh request refused on 5.
            exp = {(k == 4), (k == 4), (k >= 1 && k != 5), (k == 5)};
            got = {aux_gnt, cpu_stall, cpu_rvalid, aux_rvalid};
            exp_d = (k == 5) ? 16'h2222 : 16'h1111;
            total_cnt++;
            if (got !== exp)
                $display("FAIL starve_c%0d gnt/stall/cv/av got=%b exp=%b", k, got, exp);
            else pass_cnt++;
            if (k >= 1) begin
                total_cnt++;
                if (mem_rdata !== exp_d)
                    $display("FAIL starve_data_c%0d got=%h exp=%h", k, mem_rdata, exp_d);
                else pass_cnt++;
            end
`ifdef DMEM_ARB_PERF_EN
            if (k == 5) begin
                total_cnt++;
                if ({perf_cpu_stall, perf_aux_wait} !== {16'd1, 16'd4})
                    $display("FAIL perf_cnt got stall=%0d wait=%0d exp 1 4",
                             perf_cpu_stall, perf_aux_wait);
                else pass_cnt++;
            end
`endif
        end
        idle();
    endtask

    task automatic test_alternate();
        logic [2:0] got;
        logic [2:0] exp;
        for (int k = 0; k < 7; k++) begin
            next_cycle();
            idle();
            if (k < 6) begin
                if (k % 2 == 0) begin
                    cpu_rd_en = 1; cpu_addr = 6'd1;
                end else begin
                    aux_req = 1; aux_addr = 6'd2;
                end
            end
            #1;
            if (k >= 1) begin
                exp = (k % 2 == 1) ? 3'b100 : 3'b010;
                got = {cpu_rvalid, aux_rvalid, 1'b0};
                got[0] = (k % 2 == 1) ? (cpu_rdata !== 16'h1111) : (aux_rdata !== 16'h2222);
                total_cnt++;
                if (got !== exp)
                    $display("FAIL alt_c%0d cv/av/baddata got=%b exp=%b d=%h",
                             k, got, exp, mem_rdata);
                else pass_cnt++;
            end
        end
        idle();
    endtask

    task automatic test_write_wins();
        next_cycle();
        cpu_rd_en = 1; cpu_wr_en = 1; cpu_addr = 6'd3; cpu_wdata = 16'h00FF;
        #1;
        total_cnt++;
        if ({mem_wr_en, mem_rd_en, cpu_stall} !== 3'b100)
            $display("FAIL wr_wins_issue got wr=%b rd=%b st=%b exp 1 0 0",
                     mem_wr_en, mem_rd_en, cpu_stall);
        else pass_cnt++;
        next_cycle();
        cpu_rd_en = 0; cpu_wr_en = 1; cpu_addr = 6'd7; cpu_wdata = 16'hA5A5;
        #1;
        total_cnt++;
        if ({cpu_rvalid, ram[3]} !== {1'b0, 16'h00FF})
            $display("FAIL wr_wins_result got cv=%b ram3=%h exp 0 00ff", cpu_rvalid, ram[3]);
        else pass_cnt++;
        next_cycle();
        cpu_rd_en = 1; cpu_wr_en = 0;
        next_cycle();
        idle();
        #1;
        total_cnt++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b1, 16'hA5A5})
            $display("FAIL raw_b2b got cv=%b d=%h exp 1 a5a5", cpu_rvalid, cpu_rdata);
        else pass_cnt++;
    endtask

    task automatic test_reset_inflight();
        logic [5:0] got;
        next_cycle();
        cpu_rd_en = 1; cpu_addr = 6'd5;
        next_cycle();
        rst = 1; aux_req = 1; aux_we = 1; aux_addr = 6'd9;
        #1;
        got = {cpu_rvalid, aux_rvalid, aux_gnt, cpu_stall, mem_rd_en, mem_wr_en};
        total_cnt++;
        if (got !== 6'b0) $display("FAIL rst_inflight got=%b exp=000000", got);
        else pass_cnt++;
        next_cycle();
        rst = 0; idle();
        #1;
        total_cnt++;
        if ({cpu_rvalid, aux_rvalid} !== 2'b00)
            $display("FAIL rst_after got=%b exp=00", {cpu_rvalid, aux_rvalid});
        else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 16'h0;
        ram[1] = 16'h1111;
        ram[2] = 16'h2222;
        ram[5] = 16'h1234;
        mem_rdata = 16'h0;
        rst = 1;
        idle();
        test_reset();
        test_cpu_read();
        test_aux_write_read();
        test_starvation();
        test_alternate();
        test_write_wins();
        test_reset_inflight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
